mul_div_unit: RTL
=================

# mul_div_unit

Iterative 32-bit unsigned multiply/divide execution unit that sits directly downstream of `register_file`. It takes the two read operands `rd1_o`/`rd2_o` as `a_i`/`b_i`. It computes MUL, MULHU, DIVU or REMU with a fixed 32-iteration radix-2 algorithm. It then returns the result together with a write address and write enable that drive `register_file`'s `wd_i` / `wd_addr_i` / `we_i` write-back port.

## Interface
- `XLEN`, 32: operand/result width; counter width is clog2(XLEN)+1.
- `clk_i` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `start_i` in 1: request; sampled on rising edge, accepted only when `ready_o`=1.
- `op_i` in 2: 00 MUL (low 32 of product), 01 MULHU (high 32 of unsigned product), 10 DIVU (quotient), 11 REMU (remainder).
- `a_i` in XLEN: operand A / dividend (from `rd1_o`).
- `b_i` in XLEN: operand B / divisor (from `rd2_o`).
- `rd_addr_i` in 5: destination register address, latched with operands.
- `ready_o` out 1: unit can accept `start_i` this cycle.
- `busy_o` out 1: iteration in progress.
- `valid_o` out 1: one-cycle pulse, `result_o` valid.
- `result_o` out XLEN: result; holds last value until next result.
- `wd_addr_o` out 5: write-back address to `register_file`.
- `we_o` out 1: write-back enable = `valid_o` and `wd_addr_o` != 0.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state IDLE.
- IDLE: `ready_o`=1. On `start_i`=1: latch `op_i`, `a_i`, `b_i`, `rd_addr_i`; clear accumulator; counter=0; go to CALC. Otherwise stay in IDLE.
- CALC: `busy_o`=1, `ready_o`=0. Performs one iteration per edge, counter+1.
  - After iteration 32 (counter reaches 32), go to DONE.
  - `start_i` in CALC is ignored: no queueing, latched operands unchanged.
- Multiply: shift-add on a 64-bit {hi,lo} accumulator, lo initialised with A. Each step: if lo[0], hi += B, with carry kept in a 33-bit sum; then shift {carry,hi,lo} right by 1.
  - MUL returns lo; MULHU returns hi.
- Divide: restoring division; 33-bit partial remainder R, quotient register Q initialised with dividend. Each step: R = {R[31:0], Q[31]}, Q <<= 1; if R >= {0,B}, then R -= B and Q[0]=1.
  - DIVU returns Q; REMU returns R[31:0].
- Divide by zero needs no special path; the algorithm yields DIVU = 0xFFFFFFFF and REMU = dividend, matching RISC-V. Latency is unchanged.
- DONE: `valid_o`=1, `result_o` updated, `wd_addr_o` = latched address, `we_o` per rule above, `ready_o`=1.
  - On `start_i`=1: accept new op, go to CALC (back-to-back).
  - Else go to IDLE.
- Outside DONE: `valid_o`=0, `we_o`=0. `result_o` and `wd_addr_o` hold their last values.
- Reset assertion at any time, including mid-CALC: state IDLE immediately (async). All registers and outputs cleared. No write-back is produced for the aborted op.

## Timing
- Reset values: `ready_o`=1, `busy_o`=0, `valid_o`=0, `we_o`=0, `result_o`=0, `wd_addr_o`=0.
- Start accepted at edge k → `busy_o`=1 from edge k through edge k+32; `valid_o`/`we_o` high for exactly the cycle between edges k+32 and k+33.
- Latency: 32 cycles from accept to result, identical for all ops and all operand values.
- Throughput: one op per 33 cycles with back-to-back starts issued in DONE.
- `register_file` captures write-back at edge k+33 with `we_i`=`we_o`.
- Reset deassertion: first `start_i` may be accepted at the first rising edge after `reset` goes high.

## Test plan
- MUL a=7, b=6, rd=5, start at edge k → `valid_o` in cycle k+32..k+33, `result_o`=42, `wd_addr_o`=5, `we_o`=1. `busy_o`=0 before k and after k+32.
- MULHU a=b=0xFFFFFFFF → `result_o`=0xFFFFFFFE. MUL same operands → 0x00000001.
- DIVU a=100, b=7 → 14; REMU a=100, b=7 → 2. DIVU a=5, b=0 → 0xFFFFFFFF; REMU a=5, b=0 → 5.
- Hold `start_i` high through CALC with a second op (MUL 3×3), first op DIVU 100/7:
  - first result 14 unaffected;
  - the second op is accepted only at the DONE edge, yielding 9 exactly 33 cycles after the first `valid_o`.
- `reset`=0 at iteration 10 of MUL 7×6 → immediately `busy_o`=0, `result_o`=0; no `valid_o`/`we_o` pulse afterwards. A new MUL 2×3 after release → 6.
- MUL 2×3 with rd=0 → `valid_o`=1, `result_o`=6, `we_o`=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// Every operation takes a fixed XLEN radix-2 iterations. The result is returned
// with a write-back address/enable for register_file.
// Ports:
//   clk_i, reset (async, active-low)
//   start_i, op_i, a_i, b_i, rd_addr_i    : request and operands
//   ready_o, busy_o                       : handshake/status
//   valid_o, result_o, wd_addr_o, we_o    : result and write-back
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_addr_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wd_addr_o,
    output logic            we_o
);

    localparam int unsigned CNT_W  = $clog2(XLEN) + 1;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // hi_q is the 33-bit partial remainder for divide, and the {carry,hi} half for multiply
    logic [XLEN:0]       hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                we_q, we_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [ADDR_W-1:0]   wd_addr_q, wd_addr_d;

    logic                accept;
    logic                last_iter;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_rs;
    logic                div_fits;
    logic [XLEN:0]       iter_hi;
    logic [XLEN-1:0]     iter_lo;

    assign accept    = start_i && (state_q != S_CALC);
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // One radix-2 iteration for both algorithms.
    always_comb begin
        // Multiply: in this algorithm hi_q[XLEN] is always zero before the add.
        // The sum's carry lands in bit XLEN and is shifted back down into hi.
        mul_sum  = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
        // Divide: shift the next dividend bit in, then subtract the divisor if it fits.
        div_rs   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_fits = (div_rs >= {1'b0, b_q});
        if (op_q[1]) begin
            iter_hi = div_fits ? (div_rs - {1'b0, b_q}) : div_rs;
            iter_lo = {lo_q[XLEN-2:0], div_fits};
        end else begin
            iter_hi = {1'b0, mul_sum[XLEN:1]};
            iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // State register and datapath/output flops.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            result_q  <= '0;
            wd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            we_q      <= we_d;
            result_q  <= result_d;
            wd_addr_q <= wd_addr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = start_i ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch and iteration datapath.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        op_d  = op_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (accept) begin
            hi_d  = '0;
            lo_d  = a_i;
            b_d   = b_i;
            op_d  = op_i;
            rd_d  = rd_addr_i;
            cnt_d = '0;
        end else if (state_q == S_CALC) begin
            hi_d  = iter_hi;
            lo_d  = iter_lo;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state.
    // op_q[0] picks the upper half (MULHU, REMU), otherwise the lower half (MUL, DIVU).
    always_comb begin
        ready_d   = (state_d != S_CALC);
        busy_d    = (state_d == S_CALC);
        valid_d   = (state_q == S_CALC) && last_iter;
        we_d      = 1'b0;
        result_d  = result_q;
        wd_addr_d = wd_addr_q;
        if (valid_d) begin
            result_d  = op_q[0] ? iter_hi[XLEN-1:0] : iter_lo;
            wd_addr_d = rd_q;
            we_d      = (rd_q != '0);
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign valid_o   = valid_q;
    assign we_o      = we_q;
    assign result_o  = result_q;
    assign wd_addr_o = wd_addr_q;

endmodule
